// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time counter.
// Optional lap-hold feature in the top is enabled by STOPWATCH_LAP_HOLD_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int unsigned DIG_W = 4;
  localparam logic [DIG_W-1:0] DIG_MAX_9 = 4'd9;
  localparam logic [DIG_W-1:0] DIG_MAX_5 = 4'd5;
  localparam int unsigned TICK_HZ = 10;

  typedef struct packed {
    logic [DIG_W-1:0] min_tens;
    logic [DIG_W-1:0] min_ones;
    logic [DIG_W-1:0] sec_tens;
    logic [DIG_W-1:0] sec_ones;
    logic [DIG_W-1:0] tenths;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One BCD digit of the time chain: counts 0..MAX, carries out when it rolls over.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIG_W-1:0] MAX = DIG_MAX_9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [DIG_W-1:0] digit,
  output logic             carry
);

  logic [DIG_W-1:0] digit_q;
  logic [DIG_W-1:0] digit_d;
  logic             top_c;

  // Anything at or above MAX rolls to zero, so a corrupted digit self-heals.
  assign top_c = (digit_q >= MAX);
  assign carry = inc & top_c;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = top_c ? '0 : digit_q + DIG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch MM:SS.t BCD time counter with run/pause/clear control.
// Define STOPWATCH_LAP_HOLD_EN to add the lap freeze and the lap_active output.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter bit WRAP       = 1'b1,
  parameter bit TICK_CHECK = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start_stop_btn,
  input  logic             clear_btn,
  input  logic             lap_btn,
  output logic [DIG_W-1:0] tenths,
  output logic [DIG_W-1:0] sec_ones,
  output logic [DIG_W-1:0] sec_tens,
  output logic [DIG_W-1:0] min_ones,
  output logic [DIG_W-1:0] min_tens,
  output logic             running,
  output logic             ovf
`ifdef STOPWATCH_LAP_HOLD_EN
  ,
  output logic             lap_active
`endif
);

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   ovf_q, ovf_d;
  logic   start_q, clear_q, tick_q;

  logic   start_edge_c, clear_edge_c, count_c;
  logic   tick_inc_c, clr_c, sat_c, at_max_c;
  logic   c_tenths, c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

  bcd_time_t live_c;
  bcd_time_t disp_c;

  assign start_edge_c = start_stop_btn & ~start_q;
  assign clear_edge_c = clear_btn & ~clear_q;
  assign count_c      = tick_in & (TICK_CHECK ? ~tick_q : 1'b1);

  assign at_max_c = (live_c.tenths   == DIG_MAX_9) && (live_c.sec_ones == DIG_MAX_9) &&
                    (live_c.sec_tens == DIG_MAX_5) && (live_c.min_ones == DIG_MAX_9) &&
                    (live_c.min_tens == DIG_MAX_5);

  // Digit chain, tenths first; every carry resolves in the same cycle.
  bcd_digit #(.MAX(DIG_MAX_9)) u_tenths (
    .clk(clk), .reset(reset), .inc(tick_inc_c), .clr(clr_c),
    .digit(live_c.tenths), .carry(c_tenths)
  );
  bcd_digit #(.MAX(DIG_MAX_9)) u_sec_ones (
    .clk(clk), .reset(reset), .inc(c_tenths), .clr(clr_c),
    .digit(live_c.sec_ones), .carry(c_sec_ones)
  );
  bcd_digit #(.MAX(DIG_MAX_5)) u_sec_tens (
    .clk(clk), .reset(reset), .inc(c_sec_ones), .clr(clr_c),
    .digit(live_c.sec_tens), .carry(c_sec_tens)
  );
  bcd_digit #(.MAX(DIG_MAX_9)) u_min_ones (
    .clk(clk), .reset(reset), .inc(c_sec_tens), .clr(clr_c),
    .digit(live_c.min_ones), .carry(c_min_ones)
  );
  bcd_digit #(.MAX(DIG_MAX_5)) u_min_tens (
    .clk(clk), .reset(reset), .inc(c_min_ones), .clr(clr_c),
    .digit(live_c.min_tens), .carry(c_min_tens)
  );

  // Control FSM: a saturating overflow suppresses the increment and pauses.
  always_comb begin
    state_d    = state_q;
    tick_inc_c = 1'b0;
    clr_c      = 1'b0;
    sat_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge_c) state_d = RUN;
      end
      RUN: begin
        if (count_c) begin
          if (at_max_c && !WRAP) begin
            sat_c   = 1'b1;
            state_d = PAUSE;
          end else begin
            tick_inc_c = 1'b1;
          end
        end
        if (start_edge_c) state_d = PAUSE;
      end
      PAUSE: begin
        if (clear_edge_c) begin
          state_d = IDLE;
          clr_c   = 1'b1;
        end else if (start_edge_c) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running_d = (state_d == RUN);
    ovf_d     = ovf_q;
    if (clr_c) begin
      ovf_d = 1'b0;
    end else if (c_min_tens || sat_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
      start_q   <= start_stop_btn;
      clear_q   <= clear_btn;
      tick_q    <= tick_in;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic      lap_q;
  logic      lap_edge_c;
  logic      lap_active_q, lap_active_d;
  bcd_time_t hold_q, hold_d;

  assign lap_edge_c = lap_btn & ~lap_q;

  // Freeze captures the time shown before this cycle's tick lands.
  always_comb begin
    lap_active_d = lap_active_q;
    hold_d       = hold_q;
    if (clr_c) begin
      lap_active_d = 1'b0;
    end else if (lap_edge_c && (state_q == RUN)) begin
      lap_active_d = ~lap_active_q;
      if (!lap_active_q) hold_d = live_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q        <= 1'b0;
      lap_active_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      lap_q        <= lap_btn;
      lap_active_q <= lap_active_d;
      hold_q       <= hold_d;
    end
  end

  assign disp_c     = lap_active_q ? hold_q : live_c;
  assign lap_active = lap_active_q;
`else
  logic unused_lap_c;
  assign unused_lap_c = lap_btn;
  assign disp_c       = live_c;
`endif

  assign tenths   = disp_c.tenths;
  assign sec_ones = disp_c.sec_ones;
  assign sec_tens = disp_c.sec_tens;
  assign min_ones = disp_c.min_ones;
  assign min_tens = disp_c.min_tens;
  assign running  = running_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: three parameterisations share stimulus and are
// checked every cycle against an integer-tenths reference model.
module tb_stopwatch_time_counter;

  localparam int NDUT  = 3;
  localparam int T_MAX = 35999;

  logic clk = 1'b0;
  logic reset;
  logic tick_in, start_stop_btn, clear_btn, lap_btn;

  logic [19:0] dig_o [NDUT];
  logic        run_o [NDUT];
  logic        ovf_o [NDUT];
  logic        lap_o [NDUT];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  // dut0: WRAP=1 TICK_CHECK=0, dut1: WRAP=0 TICK_CHECK=0, dut2: WRAP=1 TICK_CHECK=1
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [3:0] t, so, st, mo, mt;
    logic       r, o;
    stopwatch_time_counter #(.WRAP(g != 1), .TICK_CHECK(g == 2)) u_dut (
      .clk(clk), .reset(reset), .tick_in(tick_in),
      .start_stop_btn(start_stop_btn), .clear_btn(clear_btn), .lap_btn(lap_btn),
      .tenths(t), .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
      .running(r), .ovf(o)
`ifdef STOPWATCH_LAP_HOLD_EN
      , .lap_active(lap_o[g])
`endif
    );
    assign dig_o[g] = {mt, mo, st, so, t};
    assign run_o[g] = r;
    assign ovf_o[g] = o;
`ifndef STOPWATCH_LAP_HOLD_EN
    assign lap_o[g] = 1'b0;
`endif
  end

  // Reference model: elapsed time as an integer count of tenths.
  int          m_t    [NDUT];
  int          m_st   [NDUT];  // 0 idle, 1 run, 2 pause
  bit          m_ovf  [NDUT];
  bit          m_lap  [NDUT];
  logic [19:0] m_hold [NDUT];
  bit ps, pc, pl, pt;

  function automatic logic [19:0] to_bcd(input int t);
    logic [19:0] r;
    r[3:0]   = 4'(t % 10);
    r[7:4]   = 4'((t / 10) % 10);
    r[11:8]  = 4'((t / 100) % 6);
    r[15:12] = 4'((t / 600) % 10);
    r[19:16] = 4'(t / 6000);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_t[k] = 0; m_st[k] = 0; m_ovf[k] = 0; m_lap[k] = 0; m_hold[k] = '0;
    end
    ps = 0; pc = 0; pl = 0; pt = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit l, input bit tk);
    bit se, ce, le, cnt, wrap;
    se = s & ~ps; ce = c & ~pc; le = l & ~pl;
    for (int k = 0; k < NDUT; k++) begin
      wrap = (k != 1);
      cnt  = tk && ((k == 2) ? !pt : 1'b1);
      case (m_st[k])
        0: if (se) m_st[k] = 1;
        1: begin
`ifdef STOPWATCH_LAP_HOLD_EN
          if (le) begin
            if (!m_lap[k]) begin m_lap[k] = 1; m_hold[k] = to_bcd(m_t[k]); end
            else m_lap[k] = 0;
          end
`endif
          if (cnt) begin
            if (m_t[k] == T_MAX) begin
              m_ovf[k] = 1;
              if (wrap) m_t[k] = 0;
              else      m_st[k] = 2;
            end else begin
              m_t[k] = m_t[k] + 1;
            end
          end
          if (se) m_st[k] = 2;
        end
        default: begin
          if (ce) begin
            m_st[k] = 0; m_t[k] = 0; m_ovf[k] = 0; m_lap[k] = 0;
          end else if (se) begin
            m_st[k] = 1;
          end
        end
      endcase
    end
    ps = s; pc = c; pl = l; pt = tk;
    if (le) ps = s;  // keeps le referenced in the default build
  endtask

  task automatic check(input string name, input int k, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d act=%h exp=%h", name, k, act, exp);
    end
  endtask

  function automatic logic [22:0] dut_vec(input int k);
    return {lap_o[k], dig_o[k], run_o[k], ovf_o[k]};
  endfunction

  task automatic compare_all(input string name);
    logic [19:0] d;
    for (int k = 0; k < NDUT; k++) begin
      d = m_lap[k] ? m_hold[k] : to_bcd(m_t[k]);
      check(name, k, dut_vec(k), {m_lap[k], d, m_st[k] == 1, m_ovf[k]});
    end
  endtask

  // Hand-computed expectation, independent of the model.
  task automatic lit(input string name, input int k, input logic [19:0] d, input bit r, input bit o);
    check(name, k, dut_vec(k), {1'b0, d, r, o});
  endtask

  task automatic cycle(input bit s, input bit c, input bit l, input bit tk);
    start_stop_btn = s; clear_btn = c; lap_btn = l; tick_in = tk;
    model_step(s, c, l, tk);
    @(posedge clk);
    #1;
    compare_all("cycle");
  endtask

  task automatic apply_reset(input bit hold_start);
    reset = 1'b1;
    start_stop_btn = hold_start; clear_btn = 0; lap_btn = 0; tick_in = 0;
    model_reset();
    #1;
    compare_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all("reset_release");
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    apply_reset(1'b0);
    for (int k = 0; k < NDUT; k++) lit("reset_state", k, 20'h00000, 1'b0, 1'b0);

    // Start then 15 ticks held high.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1);
    lit("run_15_ticks", 0, 20'h00015, 1'b1, 1'b0);
    lit("stuck_tick_once", 2, 20'h00001, 1'b1, 1'b0);

    // 600 ticks then pause; further ticks are ignored.
    apply_reset(1'b0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    lit("pause_at_1min", 0, 20'h01000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);
    lit("pause_ignores_ticks", 0, 20'h01000, 1'b0, 1'b0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    lit("pause_start_clear", 0, 20'h00000, 1'b0, 1'b0);

    // Start and clear together in IDLE runs from zero.
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    lit("idle_start_clear", 0, 20'h00000, 1'b1, 1'b0);

    random_phase(3000);

    // Preload to 59:59.9, then one more tick.
    apply_reset(1'b0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < T_MAX; i++) cycle(0, 0, 0, 1);
    lit("preload_max", 0, 20'h59599, 1'b1, 1'b0);
    cycle(0, 0, 0, 1);
    lit("wrap_to_zero", 0, 20'h00000, 1'b1, 1'b1);
    lit("saturate", 1, 20'h59599, 1'b0, 1'b1);
    lit("stuck_tick_long", 2, 20'h00001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    lit("saturate_hold", 1, 20'h59599, 1'b0, 1'b1);
    cycle(0, 1, 0, 0);
    lit("clear_after_sat", 1, 20'h00000, 1'b0, 1'b0);

    // Tick and start edge in the same RUN cycle.
    apply_reset(1'b0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    lit("tick_with_start", 0, 20'h00005, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN, start held through reset release.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
    apply_reset(1'b1);
    for (int k = 0; k < NDUT; k++) lit("after_reset", k, 20'h00000, 1'b0, 1'b0);
    cycle(1, 0, 0, 0);
    lit("held_btn_edge", 0, 20'h00000, 1'b1, 1'b0);

`ifdef STOPWATCH_LAP_HOLD_EN
    // Lap freeze at 00:02.0, 30 ticks, release shows 00:05.0.
    apply_reset(1'b0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 1, 1);
    check("lap_frozen", 0, dut_vec(0), {1'b1, 20'h00020, 1'b1, 1'b0});
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    lit("lap_release", 0, 20'h00050, 1'b1, 1'b0);
`endif

    random_phase(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
